// File: rtl/pipe_hazard_ctrl_if.sv
// ID/EX hazard-control bundle: ID and EX register indices in, pipeline enables,
// forwarding selects and performance counters out.
interface pipe_hazard_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int DEPTH = 3,
  parameter int CNT_W = 32
);
  localparam int FWD_W = $clog2(DEPTH + 1);

  logic             id_valid;
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [RA_W-1:0]  id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic [RA_W-1:0]  ex_rs1;
  logic [RA_W-1:0]  ex_rs2;
  logic             redirect;
  logic             stall_ext;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             flush_ifid;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, ex_rs1, ex_rs2, redirect, stall_ext,
    input  pc_write, ifid_write, idex_bubble, flush_ifid, fwd_a, fwd_b,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, ex_rs1, ex_rs2, redirect, stall_ext,
    output pc_write, ifid_write, idex_bubble, flush_ifid, fwd_a, fwd_b,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard unit: load-use stall, redirect flush, youngest-first
// forwarding select from a shift register of in-flight destination records.
module pipe_hazard_ctrl #(
  parameter int RA_W       = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int FWD_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } slot_t;

  slot_t            slot_q [DEPTH+1];
  slot_t            slot_d [DEPTH+1];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             luh;
  logic [FWD_W-1:0] fwd_a_sel, fwd_b_sel;
  logic             shift_en, stall_inc, flush_inc;
  slot_t            new_slot;

  function automatic logic slot_match(input slot_t s, input logic [RA_W-1:0] r);
    return s.valid && s.regwrite && (s.rd == r) && (r != '0);
  endfunction

  // Only loads sitting in slots before LOAD_STAGE-1 still lack their data.
  always_comb begin
    luh = 1'b0;
    for (int j = 0; j <= DEPTH; j++) begin
      if ((j < LOAD_STAGE - 1) && slot_q[j].memread &&
          ((hz.id_use_rs1 && slot_match(slot_q[j], hz.id_rs1)) ||
           (hz.id_use_rs2 && slot_match(slot_q[j], hz.id_rs2))))
        luh = 1'b1;
    end
    luh = luh & hz.id_valid;
  end

  // Walk from the oldest slot down so the youngest match overwrites.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (slot_match(slot_q[k], hz.ex_rs1)) fwd_a_sel = FWD_W'(k);
      if (slot_match(slot_q[k], hz.ex_rs2)) fwd_b_sel = FWD_W'(k);
    end
  end

  always_comb begin
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.idex_bubble = 1'b0;
    hz.flush_ifid  = 1'b0;
    shift_en       = 1'b1;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    new_slot       = '{valid: hz.id_valid, rd: hz.id_rd,
                       regwrite: hz.id_regwrite, memread: hz.id_memread};
    if (hz.stall_ext) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      shift_en      = 1'b0;
    end else if (hz.redirect) begin
      hz.flush_ifid  = 1'b1;
      hz.idex_bubble = 1'b1;
      new_slot       = '0;
      flush_inc      = 1'b1;
    end else if (luh) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_bubble = 1'b1;
      new_slot       = '0;
      stall_inc      = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k <= DEPTH; k++) slot_d[k] = slot_q[k];
    if (shift_en) begin
      slot_d[0] = new_slot;
      for (int k = 1; k <= DEPTH; k++) slot_d[k] = slot_q[k-1];
    end
    stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= DEPTH; k++) slot_q[k] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 0; k <= DEPTH; k++) slot_q[k] <= slot_d[k];
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.fwd_a     = fwd_a_sel;
  assign hz.fwd_b     = fwd_b_sel;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
endmodule
